// File: rtl/mhd_pkg.sv
// Shared types and defaults for the Hamming-distance pattern generator slice.
package mhd_pkg;

  typedef enum logic {IDLE, EMIT} state_t;

  localparam int MHD_WIDTH  = 34;
  localparam int MHD_THRESH = 8;

  function automatic int kw(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/mhd_next_comb.sv
// Gosper's rule: next larger value with the same popcount as mask.
// Division by the isolated low bit is replaced by a ctz-driven right shift.
module mhd_next_comb #(
  parameter int WIDTH = 34
) (
  input  logic [WIDTH-1:0] mask,
  output logic [WIDTH-1:0] next_mask
);

  localparam int EW = WIDTH + 1;
  localparam int CW = $clog2(EW);

  logic [EW-1:0] m;
  logic [EW-1:0] c;
  logic [EW-1:0] r;
  logic [CW-1:0] ctz;

  // One extra bit keeps the carry out of the top run from being lost.
  always_comb begin
    m   = {1'b0, mask};
    c   = m & (~m + EW'(1));
    r   = m + c;
    ctz = '0;
    for (int i = EW - 1; i >= 0; i--) begin
      if (c[i]) ctz = CW'(i);
    end
    next_mask = WIDTH'(((((r ^ m) >> 2) >> ctz) | r));
  end

endmodule

// File: rtl/mhd_pattern_gen.sv
// Streams every (a, b) pair whose difference mask has weight k, in ascending
// mask order, with a golden exceed flag for the Hamming-distance miter.
module mhd_pattern_gen
  import mhd_pkg::*;
#(
  parameter int WIDTH = MHD_WIDTH,
  parameter int MHD   = MHD_THRESH,
  parameter int KW    = kw(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] base,
  input  logic [KW-1:0]    k,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_a,
  output logic [WIDTH-1:0] out_b,
  output logic [WIDTH-1:0] out_mask,
  output logic             out_exceed,
  output logic             out_last,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int EW = WIDTH + 1;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] base_q;
  logic [WIDTH-1:0] mask_q;
  logic [WIDTH-1:0] top_q;
  logic [WIDTH-1:0] mask_adv;
  logic [WIDTH-1:0] top_mask;
  logic [EW-1:0]    first_mask;
  logic             exceed_q;
  logic             done_q;
  logic             err_q;
  logic             k_ok;
  logic             accept;
  logic             hs;

  mhd_next_comb #(.WIDTH(WIDTH)) u_next (
    .mask      (mask_q),
    .next_mask (mask_adv)
  );

  assign out_valid  = (state == EMIT);
  assign busy       = (state == EMIT);
  assign out_a      = base_q;
  assign out_b      = base_q ^ mask_q;
  assign out_mask   = mask_q;
  assign out_exceed = exceed_q;
  assign out_last   = (state == EMIT) && (mask_q == top_q);
  assign done       = done_q;
  assign err        = err_q;

  // The final mask is precomputed at capture so last-detect is one compare.
  always_comb begin
    k_ok       = (32'(k) <= WIDTH);
    accept     = (state == IDLE) && start && k_ok;
    hs         = out_valid && out_ready;
    first_mask = (EW'(1) << k) - EW'(1);
    top_mask   = WIDTH'(first_mask << (KW'(WIDTH) - k));
    state_nxt  = state;
    case (state)
      IDLE:    if (accept) state_nxt = EMIT;
      EMIT:    if (hs && out_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      base_q   <= '0;
      mask_q   <= '0;
      top_q    <= '0;
      exceed_q <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state  <= state_nxt;
      done_q <= hs && out_last;
      err_q  <= (state == IDLE) && start && !k_ok;
      if (accept) begin
        base_q   <= base;
        mask_q   <= WIDTH'(first_mask);
        top_q    <= top_mask;
        exceed_q <= (32'(k) > MHD);
      end else if (hs && !out_last) begin
        mask_q <= mask_adv;
      end
    end
  end

endmodule

// File: doc/mhd_pattern_gen.md
# mhd_pattern_gen

Sequential stimulus generator that drives the Hamming-distance miter from the other side. It captures a base vector and a target weight k, then streams every vector pair (a, b) whose difference mask has exactly k set bits, in ascending numeric order of the mask. Each beat carries a golden `exceed` flag, true when k > MHD, which must match the miter's `f` output. It sits between the constraint/test harness and the miter, behind a valid/ready stream.

## Interface
- `WIDTH`, 34, vector width in bits
- `MHD`, 8, distance threshold used for the golden `exceed` flag
- `KW`, $clog2(WIDTH+1), width of the weight field
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `start`  in  1  request a new enumeration; sampled only in IDLE
- `base`  in  WIDTH  base vector; captured on accepted start
- `k`  in  KW  target Hamming weight; captured on accepted start
- `out_valid`  out  1  beat present
- `out_ready`  in  1  downstream accepts beat
- `out_a`  out  WIDTH  captured base
- `out_b`  out  WIDTH  base ^ mask
- `out_mask`  out  WIDTH  current difference mask (popcount = k)
- `out_exceed`  out  1  golden miter result, (k > MHD)
- `out_last`  out  1  final mask of this enumeration
- `busy`  out  1  high from accepted start until final handshake
- `done`  out  1  one-cycle pulse after the final handshake
- `err`  out  1  one-cycle pulse when start carries k > WIDTH

## Operation
- FSM states: IDLE and EMIT.
- IDLE, start=1, k ≤ WIDTH:
  - capture `base` and `k`
  - set mask = (1<<k)-1
  - go to EMIT
- IDLE, start=1, k > WIDTH: pulse `err`, stay in IDLE, emit no beats.
- k = 0: exactly one beat with mask 0, `out_last`=1, `out_exceed`=0.
- EMIT: `out_valid`=1. On handshake (valid & ready):
  - if `out_last`: return to IDLE and pulse `done` the next cycle
  - otherwise: mask ← next_comb(mask)
- next_comb is Gosper's rule:
  - c = mask & -mask
  - r = mask + c
  - next = (((r ^ mask) >> 2) >> ctz(c)) | r
  - All arithmetic is in WIDTH+1 bits, then truncated. Shift by ctz replaces division.
- `out_last` = (mask == ((1<<k)-1) << (WIDTH-k)), i.e. the top k bits are set. Evaluate with k=0 handled separately; k = WIDTH gives a single all-ones beat.
- Outputs are stable while out_valid & !out_ready. No mask advances without a handshake.
- `start` is ignored while busy. `base` and `k` changes mid-run have no effect.
- `out_exceed` is constant for the run and is computed once at capture.

## Timing
- Reset (async assert, sync deassert by the environment) puts all outputs at 0, state at IDLE, and all registers at 0.
- Reset mid-EMIT aborts immediately: no `done` pulse and no partial beat after release.
- Latency: start accepted at edge t; `out_valid` is high after edge t.
- Throughput: one beat per cycle under continuous ready. The next mask is registered on the handshake edge.
- `done` and `busy` fall on the edge after the final handshake. A new start is accepted no earlier than the cycle `done` is high.
- `err` pulses on the edge after the offending start.
- Beats per run = C(WIDTH,k). This is at most 2.3e9 at WIDTH=34, so the optional 32-bit beat counter `beat_cnt` never wraps at default parameters.

## Structure
- Package `mhd_pkg`:
  - state enum {IDLE, EMIT}
  - `MHD_WIDTH` and `MHD_THRESH` defaults
  - function `kw(width)` = $clog2(width+1)
- Sub-module `mhd_next_comb`: purely combinational. It takes mask[WIDTH-1:0] and returns next[WIDTH-1:0], using the lowest-set-bit isolate, an adder, and a ctz priority encoder with a barrel shift.
- The top level holds the FSM, capture registers, last-detect and handshake logic.

## Test plan
- WIDTH=34, base=0, k=1, ready=1:
  - 34 beats, masks 0x1, 0x2, …, 0x2_0000_0000
  - `out_last` on beat 34 only
  - `exceed`=0
  - `done` one cycle later
- WIDTH=6, k=3:
  - 20 beats, first masks 0x07 then 0x0B then 0x0D
  - last mask 0x38
  - every popcount(out_a ^ out_b)=3
- k=0 yields one beat with mask 0 and last=1. k=34 yields one beat with mask all-ones, last=1 and exceed=1. k=35 gives an `err` pulse and no valid.
- Backpressure:
  - WIDTH=6, k=2; ready toggles in a random pattern
  - outputs hold while stalled
  - all 15 masks delivered once, in order
- Miter pairing: k=8 gives exceed=0 and k=9 gives exceed=1. The miter's f must equal `out_exceed` on every beat.
- Assert rst_n low during beat 5 of a k=2 run: outputs go to 0 at once. After release the FSM is in IDLE, a new start works, and no `done` pulse occurs.
